// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apu_pkg
//  Description : Shared constants and types for the APU frame sequencer:
//                default step tick counts, mode encodings, register bit
//                positions and the write-delay state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package apu_pkg;

    // Default tick counts at which each frame step fires
    localparam int unsigned c_STEP1    = 7457;
    localparam int unsigned c_STEP2    = 14913;
    localparam int unsigned c_STEP3    = 22371;
    localparam int unsigned c_STEP4    = 29829;
    localparam int unsigned c_STEP5    = 37281;

    // cpu_tick count between a register write and the sequencer restart
    localparam int unsigned c_WR_DELAY = 3;

    // Tick counter width; must be able to hold c_STEP5
    localparam int unsigned c_CNT_W    = 16;

    // Sequencer mode encodings (value of the mode bit)
    localparam logic c_MODE_4STEP = 1'b0;
    localparam logic c_MODE_5STEP = 1'b1;

    // Frame-counter register bit positions
    localparam int unsigned c_MODE_BIT = 7;
    localparam int unsigned c_INH_BIT  = 6;

    // RUN: free counting; PEND: counting while a write-restart is queued
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_step_decode.sv
`default_nettype none
// ============================================================================
//  Module      : frame_step_decode
//  Description : Combinational step decoder. Maps the pre-increment tick
//                count and the active mode to the quarter/half pulse
//                requests, the IRQ set request and the frame wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_step_decode
    import apu_pkg::*;
#(
    parameter int unsigned CNT_W = c_CNT_W,
    parameter int unsigned STEP1 = c_STEP1,
    parameter int unsigned STEP2 = c_STEP2,
    parameter int unsigned STEP3 = c_STEP3,
    parameter int unsigned STEP4 = c_STEP4,
    parameter int unsigned STEP5 = c_STEP5
) (
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_mode,
    output logic             o_quarter,
    output logic             o_half,
    output logic             o_irq_set,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] c_S1 = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] c_S2 = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] c_S3 = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] c_S4 = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] c_S5 = CNT_W'(STEP5);

    // Step match: STEP4 only ends the frame in 4-step mode, STEP5 only exists in 5-step mode
    always_comb begin
        o_quarter = 1'b0;
        o_half    = 1'b0;
        o_irq_set = 1'b0;
        o_wrap    = 1'b0;
        if (i_cnt == c_S1) begin
            o_quarter = 1'b1;
        end else if (i_cnt == c_S2) begin
            o_quarter = 1'b1;
            o_half    = 1'b1;
        end else if (i_cnt == c_S3) begin
            o_quarter = 1'b1;
        end else if ((i_cnt == c_S4) && (i_mode == c_MODE_4STEP)) begin
            o_quarter = 1'b1;
            o_half    = 1'b1;
            o_irq_set = 1'b1;
            o_wrap    = 1'b1;
        end else if ((i_cnt == c_S5) && (i_mode == c_MODE_5STEP)) begin
            o_quarter = 1'b1;
            o_half    = 1'b1;
            o_wrap    = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sequencer
//  Description : APU frame counter. Counts CPU-cycle ticks, emits registered
//                quarter-frame (envelope) and half-frame (length counter)
//                pulses in 4-step or 5-step mode, handles the delayed
//                restart after a frame-counter register write and drives
//                the level frame IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer
    import apu_pkg::*;
#(
    parameter int unsigned STEP1    = c_STEP1,
    parameter int unsigned STEP2    = c_STEP2,
    parameter int unsigned STEP3    = c_STEP3,
    parameter int unsigned STEP4    = c_STEP4,
    parameter int unsigned STEP5    = c_STEP5,
    parameter int unsigned WR_DELAY = c_WR_DELAY,
    parameter int unsigned CNT_W    = c_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_tick,
    input  logic       reg_wr,
    input  logic [7:0] reg_data,
    input  logic       irq_ack,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode,
    output logic [2:0] step_idx
);

    localparam int unsigned      c_DLY_W    = (WR_DELAY > 1) ? $clog2(WR_DELAY) : 1;
    localparam logic [c_DLY_W-1:0] c_DLY_LAST = c_DLY_W'(WR_DELAY - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic               w_pend_fire;

    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_step_idx;
    logic               r_mode;
    logic               r_inhibit;
    logic [c_DLY_W-1:0] r_dly;
    logic               r_quarter;
    logic               r_half;
    logic               r_irq;

    logic               w_mode_eff;
    logic               w_inh_eff;
    logic               w_dec_quarter;
    logic               w_dec_half;
    logic               w_dec_irq_set;
    logic               w_dec_wrap;
    logic               w_irq_set;
    logic               w_unused_data;

    // A write changes mode/inhibit on its own clk, so decode sees the new values immediately
    assign w_mode_eff    = reg_wr ? reg_data[c_MODE_BIT] : r_mode;
    assign w_inh_eff     = reg_wr ? reg_data[c_INH_BIT]  : r_inhibit;
    assign w_unused_data = ^reg_data[5:0];

    frame_step_decode #(
        .CNT_W (CNT_W),
        .STEP1 (STEP1),
        .STEP2 (STEP2),
        .STEP3 (STEP3),
        .STEP4 (STEP4),
        .STEP5 (STEP5)
    ) u_decode (
        .i_cnt     (r_cnt),
        .i_mode    (w_mode_eff),
        .o_quarter (w_dec_quarter),
        .o_half    (w_dec_half),
        .o_irq_set (w_dec_irq_set),
        .o_wrap    (w_dec_wrap)
    );

    // A restart tick overrides any step matched on the same tick, including its IRQ
    assign w_irq_set = cpu_tick && !w_pend_fire && w_dec_irq_set && !w_inh_eff;

    // Write-delay state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: the restart fires on the tick where the delay completes; a new write re-arms it
    always_comb begin
        w_state_nxt = r_state;
        w_pend_fire = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            ST_PEND: begin
                if (cpu_tick && (r_dly == c_DLY_LAST) && !reg_wr) begin
                    w_pend_fire = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (reg_wr) begin
            w_state_nxt = ST_PEND;
        end
    end

    // Tick counter, step index, registered pulses, mode/inhibit latch and restart delay
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_step_idx <= '0;
            r_mode     <= c_MODE_4STEP;
            r_inhibit  <= 1'b0;
            r_dly      <= '0;
            r_quarter  <= 1'b0;
            r_half     <= 1'b0;
        end else begin
            r_quarter <= 1'b0;
            r_half    <= 1'b0;

            if (reg_wr) begin
                r_mode    <= reg_data[c_MODE_BIT];
                r_inhibit <= reg_data[c_INH_BIT];
            end

            if (cpu_tick) begin
                if (w_pend_fire) begin
                    r_cnt      <= '0;
                    r_step_idx <= '0;
                    r_quarter  <= (r_mode == c_MODE_5STEP);
                    r_half     <= (r_mode == c_MODE_5STEP);
                end else begin
                    r_quarter <= w_dec_quarter;
                    r_half    <= w_dec_half;
                    if (w_dec_wrap) begin
                        r_cnt      <= '0;
                        r_step_idx <= '0;
                    end else begin
                        // Past STEP4 after a 5->4 mode switch the counter simply rolls over
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_dec_quarter) begin
                            r_step_idx <= r_step_idx + 3'd1;
                        end
                    end
                end
            end

            if (reg_wr) begin
                r_dly <= '0;
            end else if ((r_state == ST_PEND) && cpu_tick) begin
                r_dly <= r_dly + c_DLY_W'(1);
            end
        end
    end

    // Frame IRQ: an inhibit write beats a set, a set beats an acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (reg_wr && reg_data[c_INH_BIT]) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign quarter_frame = r_quarter;
    assign half_frame    = r_half;
    assign frame_irq     = r_irq;
    assign mode          = r_mode;
    assign step_idx      = r_step_idx;

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
APU frame counter that sequences the shared envelope and length-counter datapath. Counts CPU-cycle ticks and emits quarter-frame pulses (envelope clock) and half-frame pulses (length-counter clock). Supports 4-step and 5-step modes, configured by the $4017-style register write. Raises the frame IRQ to the CPU interface in 4-step mode.

Parameters:
STEP1, 7457, tick count of step 1 (quarter)
STEP2, 14913, tick count of step 2 (quarter+half)
STEP3, 22371, tick count of step 3 (quarter)
STEP4, 29829, tick count of step 4 (4-step: quarter+half+IRQ, then wrap; 5-step: no event)
STEP5, 37281, tick count of step 5 (5-step only: quarter+half, then wrap)
WR_DELAY, 3, cpu_tick count from register write to sequencer reset
CNT_W, 16, width of the tick counter (must hold STEP5)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_tick  in  1  one-clk enable per CPU cycle; all counting is qualified by it
reg_wr  in  1  one-clk write strobe for the frame-counter register
reg_data  in  8  bit7 = mode (0 = 4-step, 1 = 5-step), bit6 = IRQ inhibit; other bits ignored
irq_ack  in  1  one-clk strobe (status read) that clears frame_irq
quarter_frame  out  1  one-clk pulse that clocks the envelope units
half_frame  out  1  one-clk pulse that clocks the length counters
frame_irq  out  1  level IRQ flag
mode  out  1  current latched mode
step_idx  out  3  number of steps fired in the current frame (0..5)

Behaviour:
- Reset (rst=1 at posedge clk): cnt=0, step_idx=0, mode=0, inhibit=0, pend=0, dly=0, quarter_frame=0, half_frame=0, frame_irq=0. Reset overrides every other input, including a pending write.
- Counting: on each clk with cpu_tick=1, compare cnt against the STEPn values, then update cnt. Without cpu_tick, cnt, dly and step_idx hold.
- Events, decoded from the pre-increment cnt:
  - cnt==STEP1: quarter.
  - cnt==STEP2: quarter+half.
  - cnt==STEP3: quarter.
  - cnt==STEP4 with mode=0: quarter+half. Set frame_irq if inhibit=0. cnt<=0.
  - cnt==STEP4 with mode=1: no event. cnt increments.
  - cnt==STEP5 with mode=1: quarter+half. cnt<=0.
  - Otherwise cnt<=cnt+1.
- Each event increments step_idx. step_idx returns to 0 on wrap.
- Pulse latency: pulses are registered. They are high for exactly the one clk following the qualifying cpu_tick clk and low otherwise.
- Register write (reg_wr=1):
  - mode and inhibit latch on the same clk.
  - If bit6=1, frame_irq clears on the same clk. This clear takes priority over a same-clk IRQ set.
  - pend<=1 and dly<=0.
  - A write while pend=1 restarts the delay with the new values.
- Pending state (two states, RUN and PEND):
  - In PEND, counting and events continue normally, and dly increments per cpu_tick.
  - On the cpu_tick where dly reaches WR_DELAY-1: cnt<=0, step_idx<=0, return to RUN.
  - If mode=1 at that point, pulse quarter_frame and half_frame together, with the same 1-clk latency.
  - Any step event matched on that same tick is suppressed; the reset wins.
- IRQ:
  - frame_irq is set only by the mode-0 STEP4 event with inhibit=0.
  - frame_irq is cleared by irq_ack, by a write with bit6=1, or by rst.
  - If irq_ack and the set occur in the same clk, the set wins.
  - A mode-1 write does not clear frame_irq unless bit6=1.
- Mode change takes effect on the write clk. If mode switches 0->1 while cnt is between STEP4 and STEP5, counting continues to STEP5. If mode switches 1->0 while cnt>STEP4, cnt counts up to its max value and wraps naturally to 0 with no event.
- Arithmetic: cnt is unsigned CNT_W bits. No other widths are truncated.

Decomposition:
- Package apu_pkg holds STEP1..STEP5 defaults, the MODE_4STEP/MODE_5STEP constants, the RUN/PEND state encoding, and the reg_data bit positions (MODE_BIT=7, INH_BIT=6).
- One combinational sub-module, frame_step_decode, maps (cnt, mode) to {quarter, half, irq_set, wrap}. All state and registers stay in frame_sequencer.

Test Plan:
- Basic 4-step timing: rst, then cpu_tick held high, mode=0.
  - quarter_frame at ticks 7457, 14913, 22371, 29829.
  - half_frame at 14913 and 29829.
  - frame_irq rises 1 clk after tick 29829.
  - cnt wraps, and the next quarter comes 7458 ticks later.
- 5-step timing: write reg_data=8'h80.
  - Immediate quarter+half pulse 3 ticks after the write.
  - No event at STEP4.
  - quarter+half at STEP5.
  - frame_irq stays 0 for 3 full frames.
- IRQ control:
  - irq_ack after the IRQ sets -> frame_irq=0 next clk.
  - Write 8'h40 -> frame_irq clears the same clk, and no IRQ for 2 frames.
  - irq_ack coincident with the STEP4 tick -> frame_irq=1.
- Write restart and delay: write 8'h00, then write 8'h80 after 2 ticks.
  - Reset occurs 3 ticks after the second write, with the 5-step immediate pulse.
  - A write landing 1 tick before STEP1 suppresses nothing; a reset landing exactly on STEP1 suppresses the STEP1 pulse.
- cpu_tick gating: cpu_tick high every 3rd clk.
  - Events occur at the same tick counts, and pulses stay 1 clk wide.
- Mid-operation reset: assert rst at cnt=20000 with frame_irq=1 and pend=1.
  - All outputs go to 0, and the next quarter arrives at tick 7457 after rst deasserts.
